// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, aluop classes and flag bit positions
package alu_pkg;
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_PASS = 3'b011;
   localparam logic [2:0] ALU_NAND = 3'b100;
   localparam logic [2:0] ALU_NOR  = 3'b101;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;
   localparam logic [1:0] AOP_ADD   = 2'b00;
   localparam logic [1:0] AOP_SUB   = 2'b01;
   localparam logic [1:0] AOP_FUNCT = 2'b10;
   localparam logic [1:0] AOP_ADDI  = 2'b11;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 0;
endpackage

// File: rtl/exec_alu_unit_if.sv
// exec_alu_unit_if: ALU/adder bus.
//   master drives aluop, funct, ovr_en, ovr_ctrl, a, b, add_a, add_b
//   slave drives result, zero, alu_ctrl, flags, add_sum
interface exec_alu_unit_if #(parameter int WIDTH = 32);
   logic [1:0]       aluop;
   logic [3:0]       funct;
   logic             ovr_en;
   logic [2:0]       ovr_ctrl;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic [2:0]       alu_ctrl;
   logic [2:0]       flags;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_sum;
   modport master(output aluop, funct, ovr_en, ovr_ctrl, a, b, add_a, add_b,
                  input result, zero, alu_ctrl, flags, add_sum);
   modport slave(input aluop, funct, ovr_en, ovr_ctrl, a, b, add_a, add_b,
                 output result, zero, alu_ctrl, flags, add_sum);
endinterface

// File: rtl/add32.sv
// add32: modulo 2^WIDTH adder, no carry-out.
//   i_a, i_b : operands
//   o_sum    : i_a + i_b
module add32 #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_sum
);
   assign o_sum = i_a + i_b;
endmodule

// File: rtl/exec_alu_unit.sv
// exec_alu_unit: ALU control decode, 32-bit ALU with registered Z/N/V flags, PC adder.
//   clk, reset : clock, async active-high reset (clears flags)
//   bus        : slave side of exec_alu_unit_if (operands, control, result, flags, adder)
module exec_alu_unit
   import alu_pkg::*;
#(parameter int WIDTH = 32) (
   input logic             clk,
   input logic             reset,
   exec_alu_unit_if.slave  bus
);
   logic [2:0]       w_funct_ctrl;
   logic [2:0]       w_gout;
   logic [2:0]       w_ctrl;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_res;
   logic             w_v;
   logic [2:0]       w_flags_next;
   logic [2:0]       r_flags;
   always_comb begin
      case (bus.funct)
         4'b0010: w_funct_ctrl = ALU_SUB;
         4'b0100: w_funct_ctrl = ALU_AND;
         4'b0101: w_funct_ctrl = ALU_OR;
         4'b0111: w_funct_ctrl = ALU_NOR;
         4'b1010: w_funct_ctrl = ALU_SLT;
         default: w_funct_ctrl = ALU_ADD;
      endcase
      w_gout = (bus.aluop == AOP_FUNCT) ? w_funct_ctrl :
               (bus.aluop == AOP_SUB)   ? ALU_SUB      :
               (bus.aluop == AOP_ADD || bus.aluop == AOP_ADDI) ? ALU_ADD : ALU_ADD;
      w_ctrl = bus.ovr_en ? bus.ovr_ctrl : w_gout;
   end
   add32 #(.WIDTH(WIDTH)) u_alu_add (.i_a(bus.a), .i_b(bus.b), .o_sum(w_sum));
   add32 #(.WIDTH(WIDTH)) u_pc_add (.i_a(bus.add_a), .i_b(bus.add_b), .o_sum(bus.add_sum));
   assign w_diff = bus.a - bus.b;
   always_comb begin
      w_res = '0;
      case (w_ctrl)
         ALU_AND:  w_res = bus.a & bus.b;
         ALU_OR:   w_res = bus.a | bus.b;
         ALU_ADD:  w_res = w_sum;
         ALU_PASS: w_res = bus.a;
         ALU_NAND: w_res = ~(bus.a & bus.b);
         ALU_NOR:  w_res = ~(bus.a | bus.b);
         ALU_SUB:  w_res = w_diff;
         ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
         default:  w_res = '0;
      endcase
      // overflow only meaningful for the two arithmetic codes
      w_v = (w_ctrl == ALU_ADD) ? (bus.a[WIDTH-1] == bus.b[WIDTH-1] && w_res[WIDTH-1] != bus.a[WIDTH-1]) :
            (w_ctrl == ALU_SUB) ? (bus.a[WIDTH-1] != bus.b[WIDTH-1] && w_res[WIDTH-1] != bus.a[WIDTH-1]) :
            1'b0;
      w_flags_next = '0;
      w_flags_next[FLAG_Z] = (w_res == '0);
      w_flags_next[FLAG_N] = w_res[WIDTH-1];
      w_flags_next[FLAG_V] = w_v;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_flags <= '0;
      else       r_flags <= w_flags_next;
   end
   assign bus.result   = w_res;
   assign bus.zero     = (w_res == '0);
   assign bus.alu_ctrl = w_ctrl;
   assign bus.flags    = r_flags;
endmodule

// File: tb/tb_exec_alu_unit.sv
// tb_exec_alu_unit: scoreboard bench for exec_alu_unit with directed vectors.
module tb_exec_alu_unit;
   typedef struct {
      string       n;
      logic [2:0]  ctrl;
      logic [31:0] res;
      logic        zero;
      logic [31:0] sum;
   } comb_t;
   typedef struct {
      string      n;
      logic [2:0] f;
   } flag_t;
   logic   clk = 1'b0;
   logic   reset = 1'b1;
   int     n_pass = 0;
   int     n_total = 0;
   comb_t  cq[$];
   flag_t  fq[$];
   exec_alu_unit_if #(.WIDTH(32)) bus();
   exec_alu_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask
   task automatic issue(input string n, input logic [1:0] op, input logic [3:0] fn,
                        input logic oe, input logic [2:0] oc, input logic [31:0] a, b, aa, ab,
                        input logic [2:0] ectrl, input logic [31:0] eres, input logic [2:0] ef,
                        input logic [31:0] esum);
      comb_t c;
      flag_t f;
      @(posedge clk);
      #2;
      bus.aluop = op; bus.funct = fn; bus.ovr_en = oe; bus.ovr_ctrl = oc;
      bus.a = a; bus.b = b; bus.add_a = aa; bus.add_b = ab;
      c.n = n; c.ctrl = ectrl; c.res = eres; c.zero = (eres == 32'h0); c.sum = esum;
      f.n = n; f.f = ef;
      cq.push_back(c);
      fq.push_back(f);
   endtask
   task automatic expect_flags(input string n, input logic [2:0] ef);
      flag_t f;
      f.n = n; f.f = ef;
      fq.push_back(f);
   endtask
   always @(negedge clk) begin
      if (cq.size() != 0) begin
         comb_t c;
         c = cq.pop_front();
         chk({c.n, ".ctrl"}, {29'h0, bus.alu_ctrl}, {29'h0, c.ctrl});
         chk({c.n, ".result"}, bus.result, c.res);
         chk({c.n, ".zero"}, {31'h0, bus.zero}, {31'h0, c.zero});
         chk({c.n, ".add_sum"}, bus.add_sum, c.sum);
      end
   end
   always @(posedge clk) begin
      #1;
      if (fq.size() != 0) begin
         flag_t f;
         f = fq.pop_front();
         chk({f.n, ".flags"}, {29'h0, bus.flags}, {29'h0, f.f});
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
   initial begin
      bus.aluop = 2'b00; bus.funct = 4'h0; bus.ovr_en = 1'b0; bus.ovr_ctrl = 3'b000;
      bus.a = '0; bus.b = '0; bus.add_a = '0; bus.add_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {29'h0, bus.flags}, 32'h0);
      #2 reset = 1'b0;
      issue("dec_add",   2'b10, 4'b0000, 0, 3'b000, 32'hC, 32'hA, 32'h1, 32'h4, 3'b010, 32'h16, 3'b000, 32'h5);
      issue("dec_sub",   2'b10, 4'b0010, 0, 3'b000, 32'hC, 32'hA, 32'h1, 32'h4, 3'b110, 32'h2, 3'b000, 32'h5);
      issue("dec_and",   2'b10, 4'b0100, 0, 3'b000, 32'hC, 32'hA, 32'h1, 32'h4, 3'b000, 32'h8, 3'b000, 32'h5);
      issue("dec_or",    2'b10, 4'b0101, 0, 3'b000, 32'hC, 32'hA, 32'h1, 32'h4, 3'b001, 32'hE, 3'b000, 32'h5);
      issue("dec_nor",   2'b10, 4'b0111, 0, 3'b000, 32'hC, 32'hA, 32'h1, 32'h4, 3'b101, 32'hFFFFFFF1, 3'b010, 32'h5);
      issue("dec_slt",   2'b10, 4'b1010, 0, 3'b000, 32'hC, 32'hA, 32'h1, 32'h4, 3'b111, 32'h0, 3'b100, 32'h5);
      issue("dec_other", 2'b10, 4'b1111, 0, 3'b000, 32'hC, 32'hA, 32'h1, 32'h4, 3'b010, 32'h16, 3'b000, 32'h5);
      issue("aop00",     2'b00, 4'b0010, 0, 3'b000, 32'hC, 32'hA, 32'h1, 32'h4, 3'b010, 32'h16, 3'b000, 32'h5);
      issue("aop01",     2'b01, 4'b0000, 0, 3'b000, 32'hC, 32'hA, 32'h1, 32'h4, 3'b110, 32'h2, 3'b000, 32'h5);
      issue("aop11",     2'b11, 4'b0010, 0, 3'b000, 32'hC, 32'hA, 32'h1, 32'h4, 3'b010, 32'h16, 3'b000, 32'h5);
      issue("ovr_nand",  2'b10, 4'b0010, 1, 3'b100, 32'hC, 32'hA, 32'h1, 32'h4, 3'b100, 32'hFFFFFFF7, 3'b010, 32'h5);
      issue("add_ovf",   2'b00, 4'b0000, 0, 3'b000, 32'h7FFFFFFF, 32'h1, 32'hFFFFFFFC, 32'h4, 3'b010, 32'h80000000, 3'b011, 32'h0);
      issue("sub_zero",  2'b01, 4'b0000, 0, 3'b000, 32'h5, 32'h5, 32'h1, 32'h4, 3'b110, 32'h0, 3'b100, 32'h5);
      issue("sub_ovf",   2'b01, 4'b0000, 0, 3'b000, 32'h80000000, 32'h1, 32'h1, 32'h4, 3'b110, 32'h7FFFFFFF, 3'b001, 32'h5);
      issue("log_and",   2'b00, 4'b0000, 1, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1, 32'h4, 3'b000, 32'hF000F000, 3'b010, 32'h5);
      issue("log_or",    2'b00, 4'b0000, 1, 3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1, 32'h4, 3'b001, 32'hFFF0FFF0, 3'b010, 32'h5);
      issue("log_nor",   2'b00, 4'b0000, 1, 3'b101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1, 32'h4, 3'b101, 32'h000F000F, 3'b000, 32'h5);
      issue("log_nand",  2'b00, 4'b0000, 1, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1, 32'h4, 3'b100, 32'h0FFF0FFF, 3'b000, 32'h5);
      issue("slt_neg",   2'b00, 4'b0000, 1, 3'b111, 32'h80000000, 32'h1, 32'h1, 32'h4, 3'b111, 32'h1, 3'b000, 32'h5);
      issue("slt_pos",   2'b00, 4'b0000, 1, 3'b111, 32'h1, 32'h80000000, 32'h1, 32'h4, 3'b111, 32'h0, 3'b100, 32'h5);
      issue("slt_wrap",  2'b00, 4'b0000, 1, 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h4, 3'b111, 32'h1, 3'b000, 32'h5);
      issue("pass",      2'b00, 4'b0000, 1, 3'b011, 32'hFFFFFFFC, 32'h5, 32'h1, 32'h4, 3'b011, 32'hFFFFFFFC, 3'b010, 32'h5);
      issue("rst_load",  2'b00, 4'b0000, 0, 3'b000, 32'h7FFFFFFF, 32'h1, 32'h1, 32'h4, 3'b010, 32'h80000000, 3'b011, 32'h5);
      @(posedge clk);
      #4 reset = 1'b1;
      #1 chk("rst_async", {29'h0, bus.flags}, 32'h0);
      expect_flags("rst_hold1", 3'b000);
      expect_flags("rst_hold2", 3'b000);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      expect_flags("rst_reload", 3'b011);
      repeat (3) @(posedge clk);
      #2;
      if (cq.size() != 0 || fq.size() != 0) begin
         n_total++;
         $display("FAIL drain: got %0d pending expected 0", cq.size() + fq.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/exec_alu_unit.md
# exec_alu_unit

Execution core of the single-cycle datapath. It decodes the ALU operation from the main-control `aluop` bits and the instruction function field, or takes a forced operation code. It performs the 32-bit operation on two operands, gives a combinational result and zero indication, and registers Z/N/V status flags for the following cycle. It also contains an independent 32-bit incrementer/adder used for PC+4 and branch-target computation.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; all behaviour below assumes 32.

Ports:
- `clk`  in  1: system clock; flags update on rising edge.
- `reset`  in  1: asynchronous, active-high; clears `flags`.
- `aluop`  in  2: main-control ALU op class {aluop1, aluop0}.
- `funct`  in  4: instruction bits [3:0].
- `ovr_en`  in  1: when 1, `ovr_ctrl` replaces the decoded control.
- `ovr_ctrl`  in  3: forced ALU control code (e.g. NANDI, pass-A).
- `a`  in  32: operand A (register read data 1).
- `b`  in  32: operand B (register data 2 or extended immediate).
- `result`  out  32: ALU result, combinational.
- `zero`  out  1: `result == 0`, combinational.
- `alu_ctrl`  out  3: effective control code after override.
- `flags`  out  3: registered {Z, N, V}; reset 3'b000.
- `add_a`, `add_b`  in  32: independent adder operands.
- `add_sum`  out  32: `add_a + add_b` modulo 2^32, combinational.

## Operation
Control decode (`gout`):
- aluop 00 → 010 (ADD).
- aluop 01 → 110 (SUB).
- aluop 11 → 010 (ADD).
- aluop 10 → by `funct`:
  - 0000 → 010 ADD
  - 0010 → 110 SUB
  - 0100 → 000 AND
  - 0101 → 001 OR
  - 0111 → 101 NOR
  - 1010 → 111 SLT
  - any other value → 010 ADD
- `alu_ctrl` = `ovr_en ? ovr_ctrl : gout`.

ALU codes:
- 000 AND: a & b
- 001 OR: a | b
- 010 ADD: a + b
- 011 PASS: result = a (used for stack-pointer jump and sign test of rs)
- 100 NAND: ~(a & b)
- 101 NOR: ~(a | b)
- 110 SUB: a − b
- 111 SLT: 1 if signed a < signed b, else 0. This is a true signed compare, not the sign of a−b.

Arithmetic and flags:
- All results wrap modulo 2^32.
- Z_next = (result == 0).
- N_next = result[31].
- V_next = signed overflow for ADD/SUB, 0 for every other code:
  - ADD: a[31]==b[31] && result[31]!=a[31].
  - SUB: a[31]!=b[31] && result[31]!=a[31].
- The adder has no carry-out or overflow output and no interaction with the ALU.

## Timing
- `result`, `zero`, `alu_ctrl` and `add_sum` are combinational from their inputs, zero latency.
- `flags` captures {Z_next, N_next, V_next} on every rising `clk`, unconditionally. Consumers see the flags of the instruction executed in the previous cycle.
- `reset` asserted at any time forces `flags` to 000 immediately, independent of `clk`. While reset is held, flags stay 000.
- Combinational outputs are not affected by reset.
- If `reset` deasserts coincident with a clock edge, that edge does not load flags. The first load is on the next edge.

## Structure
- Shared package `alu_pkg`:
  - ALU control code constants: AND, OR, ADD, PASS, NAND, NOR, SUB, SLT.
  - aluop class constants.
  - Flag bit indices: Z=2, N=1, V=0.
- Sub-modules:
  - `add32`: the standalone adder, instantiated once for `add_sum`. It may be reused internally for ADD/SUB.
  - Decoder and ALU datapath are kept as separate always-blocks within the top.

## Test plan
- Decode sweep:
  - aluop=10 with funct 0000/0010/0100/0101/0111/1010/1111 → `alu_ctrl` 010/110/000/001/101/111/010.
  - aluop=00 → 010; aluop=01 → 110.
  - ovr_en=1, ovr_ctrl=100 → 100 regardless of funct.
- Arithmetic:
  - a=7FFFFFFF, b=1, ADD → result 80000000; after clk, flags=011 (N,V).
  - a=5, b=5, SUB → result 0, zero=1; after clk, flags=100.
- Logic:
  - a=F0F0F0F0, b=FF00FF00: AND=F000F000, OR=FFF0FFF0, NOR=000F000F, NAND=0FFF0FFF; V=0 for all.
- SLT and PASS:
  - a=80000000, b=1, SLT → 1.
  - a=1, b=80000000, SLT → 0.
  - PASS a=FFFFFFFC → result FFFFFFFC; after clk, N=1.
- Adder: add_a=FFFFFFFC, add_b=4 → add_sum 00000000 (wrap); add_a=1, add_b=4 → 5.
- Reset:
  - Load flags=011, then assert `reset` mid-cycle → flags 000 before the next edge.
  - Flags stay 000 through edges while reset is held.
  - Flags reload on the first edge after release.
